// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: 4-column x 5-row keypad scanner with per-frame decode,
// frame-level debounce and a one-cycle key_valid strobe.
// Optional build macro KEY_SCAN_REPEAT_EN adds auto-repeat of key_valid
// while a key stays held (period REPEAT_FRAMES frames).
module key_scan_ctrl #(
   parameter int SCAN_DIV        = 16,
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int REPEAT_FRAMES   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] key_row_in,
   output logic [3:0] key_column_out,
   output logic [4:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   // Frame/column result encoding: 0 = nothing pressed, 31 = ghost, else key code
   localparam logic [4:0] RES_NONE  = 5'd0;
   localparam logic [4:0] RES_GHOST = 5'd31;
   localparam logic [7:0] DIV_LOAD  = 8'(SCAN_DIV - 1);
   localparam logic [3:0] DEB_N     = 4'(DEBOUNCE_FRAMES);

   // Out-of-range parameters stop elaboration rather than build a broken scanner
   if (SCAN_DIV < 2 || SCAN_DIV > 255 || DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15 ||
       REPEAT_FRAMES < 1 || REPEAT_FRAMES > 255) begin : g_param_range_error
      $error("key_scan_ctrl: parameter out of legal range");
   end

   // Decode the row lines seen while column c is driven
   function automatic logic [4:0] col_decode(input logic [1:0] c, input logic [4:0] rows);
      logic [2:0] zeros;
      logic [2:0] row_idx;
      logic [4:0] res;
      zeros   = '0;
      row_idx = '0;
      for (int r = 0; r < 5; r++) begin
         if (!rows[r]) begin
            zeros   = zeros + 3'd1;
            row_idx = 3'(r);
         end
      end
      if (rows == 5'b11111)
         res = RES_NONE;
      else if (zeros == 3'd1)
         res = 5'(c) * 5'd5 + 5'(row_idx) + 5'd1;
      else if (rows == 5'b01110)
         res = 5'd21 + 5'(c);
      else
         res = RES_GHOST;
      return res;
   endfunction

   // Combine the four column results into one frame result
   function automatic logic [4:0] frame_decode(input logic [3:0][4:0] cols);
      logic [2:0] n_code;
      logic       ghost;
      logic [4:0] code;
      logic [4:0] res;
      n_code = '0;
      ghost  = 1'b0;
      code   = '0;
      for (int c = 0; c < 4; c++) begin
         if (cols[c] == RES_GHOST)
            ghost = 1'b1;
         else if (cols[c] != RES_NONE) begin
            n_code = n_code + 3'd1;
            code   = cols[c];
         end
      end
      // key 25 is rows 11110 in both column 0 and column 1 (decoded as 1 and 6)
      if (!ghost && n_code == 3'd0)
         res = RES_NONE;
      else if (cols[0] == 5'd1 && cols[1] == 5'd6 && cols[2] == RES_NONE && cols[3] == RES_NONE)
         res = 5'd25;
      else if (!ghost && n_code == 3'd1)
         res = code;
      else
         res = RES_GHOST;
      return res;
   endfunction

   // ---------------------------------------------------------------------
   // Column sequencer
   // ---------------------------------------------------------------------
   logic             run_q;
   logic [7:0]       div_q;
   logic [1:0]       col_q;
   logic [1:0]       col_d;
   logic [3:0]       col_drv_q;
   logic [2:0][4:0]  col_res_q;
   logic [4:0]       row_res;
   logic             frame_vld_q;
   logic [4:0]       frame_res_q;

   assign col_d   = col_q + 2'd1;
   assign row_res = col_decode(col_q, key_row_in);

   // Drive columns in turn; sample rows at the terminal count of each column period
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q       <= 1'b0;
         div_q       <= '0;
         col_q       <= '0;
         col_drv_q   <= 4'b1111;
         col_res_q   <= '0;
         frame_vld_q <= 1'b0;
         frame_res_q <= RES_NONE;
      end else begin
         frame_vld_q <= 1'b0;
         if (!run_q) begin
            run_q     <= 1'b1;
            div_q     <= DIV_LOAD;
            col_q     <= 2'd0;
            col_drv_q <= 4'b1110;
         end else if (div_q == 8'd0) begin
            div_q     <= DIV_LOAD;
            col_q     <= col_d;
            col_drv_q <= ~(4'b0001 << col_d);
            // shift register: after column 2, [0..2] hold columns 0..2
            col_res_q <= {row_res, col_res_q[2], col_res_q[1]};
            if (col_q == 2'd3) begin
               frame_vld_q <= 1'b1;
               frame_res_q <= frame_decode({row_res, col_res_q[2], col_res_q[1], col_res_q[0]});
            end
         end else begin
            div_q <= div_q - 8'd1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Debounce FSM, advanced once per completed frame
   //
   //   state        | meaning
   //   ST_IDLE      | no key accepted, waiting for a code frame
   //   ST_DEB_PRESS | candidate code seen cnt consecutive frames
   //   ST_HELD      | key accepted and still present
   //   ST_DEB_REL   | held key absent for rcnt consecutive frames
   // ---------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_DEB_PRESS = 2'd1,
      ST_HELD      = 2'd2,
      ST_DEB_REL   = 2'd3
   } state_t;

   state_t     state_q;
   logic [4:0] cand_q;
   logic [3:0] cnt_q;
   logic [3:0] cnt_d;
   logic [3:0] rcnt_q;
   logic [3:0] rcnt_d;
   logic [4:0] code_q;
   logic       valid_q;
   logic       held_q;
   logic       is_code;

   assign is_code = (frame_res_q != RES_NONE) && (frame_res_q != RES_GHOST);
   assign cnt_d   = (cnt_q  == 4'hF) ? cnt_q  : cnt_q  + 4'd1;
   assign rcnt_d  = (rcnt_q == 4'hF) ? rcnt_q : rcnt_q + 4'd1;

`ifdef KEY_SCAN_REPEAT_EN
   localparam logic [7:0] REP_N = 8'(REPEAT_FRAMES);
   logic [7:0] rep_q;
   logic [7:0] rep_d;
   assign rep_d = (rep_q == 8'hFF) ? rep_q : rep_q + 8'd1;
`endif

   // Per-frame debounce of press and release; key_valid is a single-cycle pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cand_q  <= RES_NONE;
         cnt_q   <= '0;
         rcnt_q  <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
`ifdef KEY_SCAN_REPEAT_EN
         rep_q   <= '0;
`endif
      end else begin
         valid_q <= 1'b0;
         if (frame_vld_q) begin
            unique case (state_q)
               ST_IDLE: begin
                  if (is_code) begin
                     cand_q <= frame_res_q;
                     cnt_q  <= 4'd1;
                     if (DEB_N == 4'd1) begin
                        code_q  <= frame_res_q;
                        valid_q <= 1'b1;
                        held_q  <= 1'b1;
                        state_q <= ST_HELD;
`ifdef KEY_SCAN_REPEAT_EN
                        rep_q   <= '0;
`endif
                     end else begin
                        state_q <= ST_DEB_PRESS;
                     end
                  end
               end
               ST_DEB_PRESS: begin
                  if (frame_res_q == cand_q) begin
                     cnt_q <= cnt_d;
                     if (cnt_d >= DEB_N) begin
                        code_q  <= cand_q;
                        valid_q <= 1'b1;
                        held_q  <= 1'b1;
                        state_q <= ST_HELD;
`ifdef KEY_SCAN_REPEAT_EN
                        rep_q   <= '0;
`endif
                     end
                  end else if (is_code) begin
                     cand_q <= frame_res_q;
                     cnt_q  <= 4'd1;
                  end else begin
                     cnt_q   <= '0;
                     state_q <= ST_IDLE;
                  end
               end
               ST_HELD: begin
                  if (frame_res_q != code_q) begin
                     if (DEB_N == 4'd1) begin
                        held_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                     end else begin
                        rcnt_q  <= 4'd1;
                        state_q <= ST_DEB_REL;
                     end
                  end
`ifdef KEY_SCAN_REPEAT_EN
                  else if (rep_d >= REP_N) begin
                     valid_q <= 1'b1;
                     rep_q   <= '0;
                  end else begin
                     rep_q <= rep_d;
                  end
`endif
               end
               ST_DEB_REL: begin
                  if (frame_res_q == code_q) begin
                     rcnt_q  <= '0;
                     state_q <= ST_HELD;
`ifdef KEY_SCAN_REPEAT_EN
                     rep_q   <= '0;
`endif
                  end else begin
                     rcnt_q <= rcnt_d;
                     if (rcnt_d >= DEB_N) begin
                        held_q  <= 1'b0;
                        rcnt_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                     end
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign key_column_out = col_drv_q;
   assign key_code       = code_q;
   assign key_valid      = valid_q;
   assign key_held       = held_q;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// tb_key_scan_ctrl: randomized and directed frame stimulus for key_scan_ctrl,
// checked cycle by cycle against a frame-level behavioural model.
`timescale 1ns/1ps
module tb_key_scan_ctrl;
   localparam int SCAN_DIV = 16;
   localparam int DEB      = 3;
   localparam int REP      = 8;
   localparam int FRAME    = 4 * SCAN_DIV;

   localparam logic [4:0] R_NONE = 5'b11111;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] key_row_in;
   logic [3:0] key_column_out;
   logic [4:0] key_code;
   logic       key_valid;
   logic       key_held;

   key_scan_ctrl #(
      .SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DEB), .REPEAT_FRAMES(REP)
   ) dut (
      .clk(clk), .rst(rst), .key_row_in(key_row_in), .key_column_out(key_column_out),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
   );

   always #50 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Key matrix: rows follow the driven column(s), settling half a cycle after a column change
   logic [4:0] pat [4];
   always @(negedge clk) begin : matrix
      logic [4:0] r;
      r = 5'b11111;
      for (int c = 0; c < 4; c++)
         if (!key_column_out[c]) r = r & pat[c];
      key_row_in = r;
   end

   // ---------------- behavioural model ----------------
   int  m_code, m_rel, m_rep, m_pulses;
   bit  m_held;
   int  hist[$];
   bit  pend_vld;
   int  pend_res;
   int  n_pulses, last_valid_cyc, rel_cyc;

   function automatic int col_code(int c, logic [4:0] p);
      logic [4:0] inv;
      inv = ~p;
      if (p == 5'b11111) return 0;
      if ($countones(inv) == 1)
         for (int r = 0; r < 5; r++) if (!p[r]) return c * 5 + r + 1;
      if (p == 5'b01110) return 21 + c;
      return 31;
   endfunction

   function automatic int frame_result(logic [4:0] p0, logic [4:0] p1, logic [4:0] p2, logic [4:0] p3);
      int cc[4];
      int n, code;
      bit g;
      n = 0; code = 0; g = 0;
      if (p0 == 5'b11110 && p1 == 5'b11110 && p2 == R_NONE && p3 == R_NONE) return 25;
      cc[0] = col_code(0, p0); cc[1] = col_code(1, p1);
      cc[2] = col_code(2, p2); cc[3] = col_code(3, p3);
      for (int c = 0; c < 4; c++) begin
         if (cc[c] == 31) g = 1;
         else if (cc[c] != 0) begin n++; code = cc[c]; end
      end
      if (g || n > 1) return 31;
      if (n == 1) return code;
      return 0;
   endfunction

   // One frame result in; returns whether key_valid should pulse for it
   task automatic model_step(input int res, output bit pulse);
      bit same;
      pulse = 0;
      if (m_held) begin
         if (res == m_code) begin
            if (m_rel > 0) begin m_rel = 0; m_rep = 0; end
            else begin
               m_rep++;
`ifdef KEY_SCAN_REPEAT_EN
               if (m_rep == REP) begin pulse = 1; m_rep = 0; end
`endif
            end
         end else begin
            m_rel++;
            if (m_rel >= DEB) begin m_held = 0; m_rel = 0; hist.delete(); end
         end
      end else begin
         hist.push_back(res);
         if (hist.size() > DEB) void'(hist.pop_front());
         if (hist.size() == DEB && res >= 1 && res <= 25) begin
            same = 1;
            foreach (hist[i]) if (hist[i] != res) same = 0;
            if (same) begin
               pulse = 1; m_code = res; m_held = 1; m_rel = 0; m_rep = 0; hist.delete();
            end
         end
      end
      if (pulse) m_pulses++;
   endtask

   // Run one scan frame with the given column patterns, checking the DUT every cycle
   task automatic run_frame(input logic [4:0] p0, input logic [4:0] p1,
                            input logic [4:0] p2, input logic [4:0] p3);
      bit         pulse, exp_v;
      logic [3:0] exp_col;
      int         res_now;
      pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
      res_now = frame_result(p0, p1, p2, p3);
      for (int j = 0; j < FRAME; j++) begin
         exp_v = 1'b0;
         if (j == 1 && pend_vld) begin
            model_step(pend_res, pulse);
            exp_v = pulse;
         end
         checks++;
         if (key_valid !== exp_v) begin
            errors++;
            $display("FAIL key_valid cyc=%0d phase=%0d: got %b expected %b", cyc, j, key_valid, exp_v);
         end
         if (key_valid === 1'b1) begin n_pulses++; last_valid_cyc = cyc; end
         if (j == 0 || j == 1 || j == FRAME - 1) begin
            checks++;
            if (key_code !== 5'(m_code)) begin
               errors++;
               $display("FAIL key_code cyc=%0d phase=%0d: got %0d expected %0d", cyc, j, key_code, m_code);
            end
            checks++;
            if (key_held !== m_held) begin
               errors++;
               $display("FAIL key_held cyc=%0d phase=%0d: got %b expected %b", cyc, j, key_held, m_held);
            end
         end
         if (j % SCAN_DIV == 0 || j % SCAN_DIV == SCAN_DIV - 1) begin
            exp_col = 4'b1111 ^ (4'b0001 << (j / SCAN_DIV));
            checks++;
            if (key_column_out !== exp_col) begin
               errors++;
               $display("FAIL column cyc=%0d phase=%0d: got %b expected %b", cyc, j, key_column_out, exp_col);
            end
         end
         @(negedge clk);
      end
      pend_res = res_now;
      pend_vld = 1;
   endtask

   task automatic run_n(input int n, input logic [4:0] p0, input logic [4:0] p1,
                        input logic [4:0] p2, input logic [4:0] p3);
      for (int i = 0; i < n; i++) run_frame(p0, p1, p2, p3);
   endtask

   // Hold reset a few cycles, release it, and leave the bench at the first frame phase
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) pat[c] = R_NONE;
      repeat (3) @(negedge clk);
      m_code = 0; m_held = 0; m_rel = 0; m_rep = 0; m_pulses = 0;
      hist.delete();
      pend_vld = 0;
      n_pulses = 0;
      last_valid_cyc = 0;
      #1 rst = 1'b1;
      rel_cyc = cyc;
      @(negedge clk);
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if (key_column_out !== 4'b1111 || key_code !== 5'd0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
         errors++;
         $display("FAIL %s: got col=%b code=%0d valid=%b held=%b expected 1111/0/0/0",
                  name, key_column_out, key_code, key_valid, key_held);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0;
      #1 check_reset_outputs("reset_values");
      do_reset();
      run_n(2, R_NONE, R_NONE, R_NONE, R_NONE);
   endtask

   task automatic test_single_key();
      do_reset();
      run_n(4, R_NONE, 5'b11101, R_NONE, R_NONE);
      check_int("key7_pulses", n_pulses, 1);
      check_int("key7_latency", last_valid_cyc - rel_cyc - 1, DEB * FRAME + 1);
      check_int("key7_held", int'(key_held), 1);
      run_n(4, R_NONE, R_NONE, R_NONE, R_NONE);
      check_int("key7_released", int'(key_held), 0);
      check_int("key7_code_kept", int'(key_code), 7);
   endtask

   task automatic test_special_keys();
      do_reset();
      run_n(4, R_NONE, 5'b01110, R_NONE, R_NONE);
      run_n(4, R_NONE, R_NONE, R_NONE, R_NONE);
      check_int("key22_code", int'(key_code), 22);
      run_n(4, 5'b11110, 5'b11110, R_NONE, R_NONE);
      run_n(4, R_NONE, R_NONE, R_NONE, R_NONE);
      check_int("key25_code", int'(key_code), 25);
      check_int("special_pulses", n_pulses, 2);
   endtask

   // Continues from the previous scenario so key_code is non-zero before the reset
   task automatic test_reset_mid_debounce();
      run_n(2, R_NONE, R_NONE, 5'b11101, R_NONE);
      repeat (20) @(negedge clk);
      #1 rst = 1'b0;
      #1 check_reset_outputs("reset_mid_debounce");
      do_reset();
      run_n(4, R_NONE, R_NONE, 5'b11101, R_NONE);
      run_n(4, R_NONE, R_NONE, R_NONE, R_NONE);
      check_int("key12_pulses", n_pulses, 1);
      check_int("key12_latency", last_valid_cyc - rel_cyc - 1, DEB * FRAME + 1);
      check_int("key12_code", int'(key_code), 12);
   endtask

   task automatic test_bounce();
      do_reset();
      for (int i = 0; i < 10; i++)
         if (i % 2 == 0) run_frame(5'b11011, R_NONE, R_NONE, R_NONE);
         else            run_frame(R_NONE, R_NONE, R_NONE, R_NONE);
      run_n(2, R_NONE, R_NONE, R_NONE, R_NONE);
      check_int("bounce_pulses", n_pulses, 0);
      check_int("bounce_held", int'(key_held), 0);
   endtask

   task automatic test_ghost();
      do_reset();
      run_n(6, 5'b11110, R_NONE, R_NONE, 5'b11110);
      run_n(2, R_NONE, R_NONE, R_NONE, R_NONE);
      check_int("ghost_pulses", n_pulses, 0);
      check_int("ghost_held", int'(key_held), 0);
   endtask

   task automatic test_random();
      logic [4:0] pool [8][4];
      int sel;
      pool[0] = '{R_NONE, R_NONE, R_NONE, R_NONE};
      pool[1] = '{R_NONE, 5'b11101, R_NONE, R_NONE};
      pool[2] = '{5'b11011, R_NONE, R_NONE, R_NONE};
      pool[3] = '{R_NONE, 5'b01110, R_NONE, R_NONE};
      pool[4] = '{5'b11110, 5'b11110, R_NONE, R_NONE};
      pool[5] = '{5'b11110, R_NONE, R_NONE, 5'b11110};
      pool[6] = '{R_NONE, R_NONE, 5'b11101, R_NONE};
      pool[7] = '{5'b10100, R_NONE, R_NONE, R_NONE};
      do_reset();
      sel = 0;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) < 3) sel = int'($urandom_range(0, 7));
         run_frame(pool[sel][0], pool[sel][1], pool[sel][2], pool[sel][3]);
      end
      run_n(4, R_NONE, R_NONE, R_NONE, R_NONE);
      check_int("random_pulse_count", n_pulses, m_pulses);
   endtask

`ifdef KEY_SCAN_REPEAT_EN
   task automatic test_repeat();
      do_reset();
      run_n(23, R_NONE, R_NONE, R_NONE, 5'b11011);
      run_n(4, R_NONE, R_NONE, R_NONE, R_NONE);
      check_int("repeat_pulses", n_pulses, 3);
      check_int("repeat_code", int'(key_code), 18);
   endtask
`endif

   initial begin
      for (int c = 0; c < 4; c++) pat[c] = R_NONE;
      test_reset();
      test_single_key();
      test_special_keys();
      test_reset_mid_debounce();
      test_bounce();
      test_ghost();
      test_random();
`ifdef KEY_SCAN_REPEAT_EN
      test_repeat();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/key_scan_ctrl.md
# key_scan_ctrl

Keypad scan controller for the 4-column × 5-row key matrix. It drives one column low at a time and samples the five row lines. It decodes each full scan frame into a key code and debounces that code across frames. It then issues a one-cycle `key_valid` strobe with a stable `key_code` to downstream logic. It sits between the key matrix (or the `key_pad` simulation model) and the application logic, on the 10 MHz system clock.

## Interface
Parameters:
- `SCAN_DIV`, 16: clock cycles each column is driven; legal range 2..255.
- `DEBOUNCE_FRAMES`, 3: number of consecutive identical frames required to accept a press or a release; legal range 1..15.
- `REPEAT_FRAMES`, 8: auto-repeat period in frames; used only when `KEY_SCAN_REPEAT_EN` is defined; legal range 1..255.

Ports:
- `clk` input 1: 10 MHz system clock, rising edge.
- `rst` input 1: asynchronous reset, active low.
- `key_row_in` input 5: row lines; a low bit means the row is pressed in the currently driven column.
- `key_column_out` output 4: column drive; one bit low at a time; reset value 4'b1111.
- `key_code` output 5: last accepted code, 1..25; reset value 0.
- `key_valid` output 1: one-cycle strobe marking a new accepted code; reset value 0.
- `key_held` output 1: high while the accepted key remains pressed; reset value 0.

## Operation
- Column sequencer:
  - Order is 4'b1110 → 1101 → 1011 → 0111 → wrap to 1110.
  - Each column is driven for `SCAN_DIV` cycles.
  - Four columns make one frame of 4·`SCAN_DIV` cycles.
- Row sampling: `key_row_in` is sampled on the last cycle of each column period. This absorbs the one-cycle registered row response of the matrix model.
- Per-column decode, for column c:
  - Row r is the only low row: code c·5+r+1, giving 1..20.
  - Pattern 5'b01110: code 21+c, giving 21..24.
  - Pattern 5'b11111: no key in that column.
  - Any other pattern: ghost.
- Frame decode, from the four column results:
  - All columns empty: frame result is NONE.
  - Exactly one column holds a code and no column is ghost: frame result is that code.
  - Column 0 = 11110, column 1 = 11110, columns 2 and 3 empty: frame result is 25.
  - Anything else: frame result is GHOST.
- State machine, advanced once per frame end:
  - IDLE:
    - A code frame loads the candidate, sets cnt=1, and moves to DEB_PRESS. If `DEBOUNCE_FRAMES`=1, it goes straight to accept.
  - DEB_PRESS:
    - Same code: cnt+1. When cnt reaches `DEBOUNCE_FRAMES`, accept: latch `key_code`, pulse `key_valid`, set `key_held`=1, go to HELD.
    - Different code: reload the candidate with cnt=1.
    - NONE or GHOST: return to IDLE.
  - HELD:
    - Any frame other than the held code (NONE, GHOST, or a different code) starts the release count: rcnt=1, go to DEB_REL.
  - DEB_REL:
    - Held code seen again: return to HELD.
    - Otherwise rcnt+1. When rcnt reaches `DEBOUNCE_FRAMES`, clear `key_held` and go to IDLE.
    - A new key is only accepted after a full release.
- Counters saturate and never wrap. `key_code` keeps its last value after release.
- Reset, asynchronous, may arrive mid-frame or mid-debounce:
  - All state and counters are cleared.
  - Outputs return to their reset values.
  - No `key_valid` is emitted.

## Timing
- First cycle after reset deassertion: `key_column_out` = 4'b1110 and the frame starts at column 0.
- `key_valid` and `key_code` update on the cycle after the final sample of the accepting frame.
- Press latency from a stable press present from the start of a frame: `DEBOUNCE_FRAMES`·4·`SCAN_DIV`+1 cycles. With defaults this is 193 cycles (19.3 µs).
- `key_held` falls on the cycle after the final sample of the frame that completes the release count.
- `key_valid` is never high for two consecutive cycles.

## Configuration
- `KEY_SCAN_REPEAT_EN` defined:
  - While in HELD, `key_valid` re-pulses with the same `key_code` every `REPEAT_FRAMES` consecutive held-code frames after acceptance.
  - The repeat count resets on entry to HELD.
- Not defined: exactly one `key_valid` per press, and the repeat logic is absent.

## Test plan
- Hold key 7 (column 1, rows 11101), defaults → single `key_valid` with `key_code`=7 at 193 cycles after frame start; `key_held`=1.
- Press key 22 (column 1 = 01110), then key 25 (columns 0 and 1 = 11110) → codes 22 and 25 accepted, each after a full release.
- Key 3 toggling pressed/released every frame for 10 frames → no `key_valid`, `key_held` stays 0.
- Assert `rst` low after 2 of 3 debounce frames of key 12 → outputs return to 1111/0/0/0 immediately; after release, re-press gives exactly one `key_valid` with code 12, 193 cycles after the first full frame.
- Keys 1 and 16 held together (two columns active) → GHOST frames, no `key_valid`.
- With `KEY_SCAN_REPEAT_EN`, `REPEAT_FRAMES`=8, key 18 held for 20 frames after acceptance → `key_valid` pulses at acceptance, then at +8 and +16 frames, `key_code`=18 each time.
